// File: rtl/rlight_seq_pkg.sv
// rtl/rlight_seq_pkg.sv - shared types, register addresses and step function for the running-light sequencer
package rlight_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ROL    = 2'b00,
    MODE_ROR    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [3:0] ADDR_CTRL     = 4'h0;
  localparam logic [3:0] ADDR_PRESCALE = 4'h4;
  localparam logic [3:0] ADDR_PATTERN  = 4'h8;
  localparam logic [3:0] ADDR_STATUS   = 4'hC;

  localparam int ONESHOT_STEPS  = 8;
  localparam int PRESCALE_RESET = 999_999;

  // Returns {dir, led} after one step in the given mode.
  function automatic logic [8:0] step_led(mode_e mode, logic dir, logic [7:0] led);
    logic [8:0] r;
    r = {dir, led};
    case (mode)
      MODE_ROL: r[7:0] = {led[6:0], led[7]};
      MODE_ROR: r[7:0] = {led[0], led[7:1]};
      MODE_BOUNCE: begin
        if (led != 8'h00) begin
          if (!dir && !led[7])  r = {1'b0, led[6:0], 1'b0};
          else if (!dir)        r = {1'b1, 1'b0, led[7:1]};
          else if (!led[0])     r = {1'b1, 1'b0, led[7:1]};
          else                  r = {1'b0, led[6:0], 1'b0};
        end
      end
      default: r = {dir, led};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rlight_prescaler.sv
// rtl/rlight_prescaler.sv - reloadable down-counter issuing a one-cycle tick at zero
module rlight_prescaler #(
  parameter int PRESCALE_W = 24
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  run_i,
  input  logic [PRESCALE_W-1:0] reload_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q;

  assign tick_o = run_i && (cnt_q == '0);

  // An explicit load wins over the tick reload; both use the same reload value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i || tick_o) begin
      cnt_q <= reload_i;
    end else if (run_i) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/rlight_sequencer.sv
// rtl/rlight_sequencer.sv - register-programmable running-light sequencer for the 8 board LEDs
module rlight_sequencer
  import rlight_seq_pkg::*;
#(
  parameter int         PRESCALE_W = 24,
  parameter logic [7:0] LED_RESET  = 8'h01
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_we_i,
  input  logic        reg_re_i,
  input  logic [3:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic [31:0] reg_rdata_o,
  output logic [7:0]  led_o
);

  state_e                state_q, state_d;
  logic [3:0]            ctrl_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [7:0]            pattern_q;
  logic [7:0]            led_q;
  logic [7:0]            step_cnt_q;
  logic                  dir_q;
  logic                  done_q;

  logic ctrl_wr, pre_wr, pat_wr;
  logic tick, start, step_en, finish;
  logic unused_wdata;

  assign ctrl_wr      = reg_we_i && (reg_addr_i == ADDR_CTRL);
  assign pre_wr       = reg_we_i && (reg_addr_i == ADDR_PRESCALE);
  assign pat_wr       = reg_we_i && (reg_addr_i == ADDR_PATTERN);
  assign unused_wdata = ^reg_wdata_i;

  rlight_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (start || pat_wr),
    .run_i    (state_q == RUN),
    .reload_i (prescale_q),
    .tick_o   (tick)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A disabling CTRL write or a PATTERN write on a tick cycle discards that step.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    step_en = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_wr && reg_wdata_i[0]) begin
          state_d = RUN;
          start   = 1'b1;
        end
      end
      RUN: begin
        if (ctrl_wr && !reg_wdata_i[0]) begin
          state_d = IDLE;
        end else if (tick && !pat_wr) begin
          step_en = 1'b1;
          if (ctrl_q[3] && (step_cnt_q == 8'(ONESHOT_STEPS - 1))) begin
            state_d = IDLE;
            finish  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q     <= 4'h0;
      prescale_q <= PRESCALE_W'(PRESCALE_RESET);
      pattern_q  <= LED_RESET;
      led_q      <= LED_RESET;
      step_cnt_q <= 8'h00;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl_q <= reg_wdata_i[3:0];
        done_q <= 1'b0;
      end
      if (pre_wr) prescale_q <= reg_wdata_i[PRESCALE_W-1:0];
      if (start) begin
        step_cnt_q <= 8'h00;
        dir_q      <= 1'b0;
      end
      if (step_en) begin
        {dir_q, led_q} <= step_led(mode_e'(ctrl_q[2:1]), dir_q, led_q);
        step_cnt_q     <= step_cnt_q + 8'h01;
      end
      if (finish) begin
        ctrl_q[0] <= 1'b0;
        done_q    <= 1'b1;
      end
      if (pat_wr) begin
        pattern_q  <= reg_wdata_i[7:0];
        led_q      <= reg_wdata_i[7:0];
        step_cnt_q <= 8'h00;
      end
    end
  end

  always_comb begin
    reg_rdata_o = 32'h0;
    if (reg_re_i) begin
      case (reg_addr_i)
        ADDR_CTRL:     reg_rdata_o = {28'h0, ctrl_q};
        ADDR_PRESCALE: reg_rdata_o = 32'(prescale_q);
        ADDR_PATTERN:  reg_rdata_o = {24'h0, pattern_q};
        ADDR_STATUS:   reg_rdata_o = {13'h0, done_q, (state_q == RUN), dir_q, step_cnt_q, led_q};
        default:       reg_rdata_o = 32'h0;
      endcase
    end
  end

  assign led_o = led_q;

endmodule
